// File: rtl/set_assoc_icache.sv
// N-way set-associative instruction cache with per-set round-robin replacement and FENCE.I invalidate.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module set_assoc_icache #(
    parameter int INDEX_BITS = 8,
    parameter int WAYS       = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        invalidate_all,
    input  logic [31:0] read_addr,
    input  logic        is_reading,
    output logic [31:0] read_data,
    output logic        is_ready,
    output logic        icache_available,
    input  logic [31:0] ins_fetched_from_memory_adaptor,
    input  logic        insfetch_task_done,
    output logic        request_ins_from_memory_adaptor,
    output logic [31:0] insaddr_to_be_fetched_from_memory_adaptor
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 1;
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [31:0]         fill_addr_q, fill_addr_d;
    logic [WAYS-1:0]     valid_q  [SETS];
    logic [WAY_BITS-1:0] victim_q [SETS];
    logic [TAG_BITS-1:0] tag_q    [SETS][WAYS];
    logic [31:0]         data_q   [SETS][WAYS];

    logic [31:0]           lookup_addr;
    logic [INDEX_BITS-1:0] lk_index;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  unused_addr_bit0;
    logic [WAY_BITS-1:0]   cur_victim, next_victim;
    logic                  hit;
    logic [31:0]           hit_data;
    logic                  hit_fire;
    logic                  fill_we;

    // While filling, the lookup follows the latched miss address rather than the live fetch address.
    assign lookup_addr      = (state_q == S_FILL) ? fill_addr_q : read_addr;
    assign lk_index         = lookup_addr[INDEX_BITS:1];
    assign lk_tag           = lookup_addr[31:INDEX_BITS+1];
    assign unused_addr_bit0 = lookup_addr[0];
    assign cur_victim       = victim_q[lk_index];
    assign next_victim      = (WAYS == 1) ? '0 : cur_victim + WAY_BITS'(1);

    // Ways hold distinct tags, so at most one matches and OR-ing the data is a clean mux.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_index][w] && (tag_q[lk_index][w] == lk_tag)) begin
                hit      = 1'b1;
                hit_data = hit_data | data_q[lk_index][w];
            end
        end
    end

    always_comb begin
        state_d                                   = state_q;
        fill_addr_d                               = fill_addr_q;
        fill_we                                   = 1'b0;
        hit_fire                                  = 1'b0;
        is_ready                                  = 1'b0;
        read_data                                 = '0;
        request_ins_from_memory_adaptor           = 1'b0;
        icache_available                          = (state_q == S_IDLE);
        insaddr_to_be_fetched_from_memory_adaptor = lookup_addr;
        case (state_q)
            S_IDLE: begin
                if (rdy_in && is_reading) begin
                    if (hit) begin
                        hit_fire  = 1'b1;
                        is_ready  = 1'b1;
                        read_data = hit_data;
                    end else begin
                        request_ins_from_memory_adaptor = 1'b1;
                        if (flush_pipline) begin
                            state_d = S_IDLE;
                        end else if (insfetch_task_done) begin
                            is_ready  = 1'b1;
                            read_data = ins_fetched_from_memory_adaptor;
                            fill_we   = 1'b1;
                        end else begin
                            fill_addr_d = read_addr;
                            state_d     = S_FILL;
                        end
                    end
                end
            end
            S_FILL: begin
                if (rdy_in) begin
                    if (flush_pipline) begin
                        state_d = S_IDLE;
                    end else if (insfetch_task_done) begin
                        is_ready  = 1'b1;
                        read_data = ins_fetched_from_memory_adaptor;
                        fill_we   = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            fill_addr_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]  <= '0;
                victim_q[s] <= '0;
            end
        end else if (rdy_in) begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            // Invalidate beats a same-cycle fill so no stale line survives FENCE.I.
            if (invalidate_all) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end else if (fill_we) begin
                valid_q[lk_index][cur_victim] <= 1'b1;
            end
            if (fill_we) begin
                victim_q[lk_index] <= next_victim;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && fill_we) begin
            tag_q[lk_index][cur_victim]  <= lk_tag;
            data_q[lk_index][cur_victim] <= ins_fetched_from_memory_adaptor;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_fire) begin
                hit_count <= hit_count + 32'd1;
            end
            if (request_ins_from_memory_adaptor) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_set_assoc_icache.sv
// Directed bench for set_assoc_icache (INDEX_BITS=8, WAYS=2); counter checks build when ICACHE_PERF_EN is defined.
module tb_set_assoc_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        invalidate_all;
    logic [31:0] read_addr;
    logic        is_reading;
    logic [31:0] read_data;
    logic        is_ready;
    logic        icache_available;
    logic [31:0] ad_data;
    logic        done;
    logic        request;
    logic [31:0] fill_addr;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    // The adaptor model returns a word derived from the address the fetch stage holds.
    assign ad_data = mem_word(read_addr);

    set_assoc_icache #(.INDEX_BITS(8), .WAYS(2)) dut (
        .clk_in                                    (clk_in),
        .rst_in                                    (rst_in),
        .rdy_in                                    (rdy_in),
        .flush_pipline                             (flush_pipline),
        .invalidate_all                            (invalidate_all),
        .read_addr                                 (read_addr),
        .is_reading                                (is_reading),
        .read_data                                 (read_data),
        .is_ready                                  (is_ready),
        .icache_available                          (icache_available),
        .ins_fetched_from_memory_adaptor           (ad_data),
        .insfetch_task_done                        (done),
        .request_ins_from_memory_adaptor           (request),
        .insaddr_to_be_fetched_from_memory_adaptor (fill_addr)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count                                 (hit_count),
        .miss_count                                (miss_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] addr, input int lat);
        read_addr  = addr;
        is_reading = 1'b1;
        done       = 1'b0;
        settle();
        check("miss_req", 32'(request), 32'd1);
        check("miss_avail", 32'(icache_available), 32'd1);
        check("miss_rdy", 32'(is_ready), 32'd0);
        check("miss_faddr", fill_addr, addr);
        tick();
        for (int k = 1; k <= lat; k++) begin
            done = (k == lat);
            settle();
            check("fill_avail", 32'(icache_available), 32'd0);
            check("fill_req", 32'(request), 32'd0);
            check("fill_rdy", 32'(is_ready), 32'(k == lat));
            if (k == lat) check("fill_data", read_data, mem_word(addr));
            tick();
        end
        done       = 1'b0;
        is_reading = 1'b0;
    endtask

    task automatic probe_hit(input logic [31:0] addr);
        read_addr  = addr;
        is_reading = 1'b1;
        settle();
        check("hit_rdy", 32'(is_ready), 32'd1);
        check("hit_data", read_data, mem_word(addr));
        check("hit_req", 32'(request), 32'd0);
        tick();
        is_reading = 1'b0;
    endtask

    // A flushed IDLE miss still requests but leaves the cache untouched.
    task automatic probe_miss(input logic [31:0] addr);
        read_addr     = addr;
        is_reading    = 1'b1;
        flush_pipline = 1'b1;
        settle();
        check("pm_req", 32'(request), 32'd1);
        check("pm_rdy", 32'(is_ready), 32'd0);
        check("pm_faddr", fill_addr, addr);
        tick();
        flush_pipline = 1'b0;
        is_reading    = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_pipline = 1'b0; invalidate_all = 1'b0;
        read_addr = 32'h0000_1234; is_reading = 1'b0; done = 1'b0;
        #1;
        do_reset();
        settle();
        check("rst_ready", 32'(is_ready), 32'd0);
        check("rst_req", 32'(request), 32'd0);
        check("rst_avail", 32'(icache_available), 32'd1);
        check("rst_data", read_data, 32'd0);
        check("rst_faddr", fill_addr, 32'h0000_1234);
        tick();

        // Cold miss with three-cycle fill, then same-cycle hit.
        do_miss(32'h100, 3);
        probe_hit(32'h100);

        // Three tags in set 0x80: third fill evicts way0.
        do_miss(32'h300, 2);
        do_miss(32'h500, 1);
        probe_hit(32'h300);
        probe_hit(32'h500);
        probe_miss(32'h100);

        // Flush during fill, then a stray done in IDLE.
        read_addr = 32'h200; is_reading = 1'b1;
        tick();
        flush_pipline = 1'b1;
        settle();
        check("fl_rdy", 32'(is_ready), 32'd0);
        tick();
        flush_pipline = 1'b0; is_reading = 1'b0; done = 1'b1;
        settle();
        check("stray_rdy", 32'(is_ready), 32'd0);
        check("stray_avail", 32'(icache_available), 32'd1);
        tick();
        done = 1'b0;
        // Flush and done in the same FILL cycle: flush wins.
        read_addr = 32'h200; is_reading = 1'b1;
        tick();
        flush_pipline = 1'b1; done = 1'b1;
        settle();
        check("fldone_rdy", 32'(is_ready), 32'd0);
        tick();
        flush_pipline = 1'b0; done = 1'b0; is_reading = 1'b0;
        probe_miss(32'h200);

        // FENCE.I invalidate.
        do_miss(32'h40, 1);
        probe_hit(32'h40);
        invalidate_all = 1'b1;
        tick();
        invalidate_all = 1'b0;
        probe_miss(32'h40);
        probe_miss(32'h300);

        // Zero-latency fill, then rdy_in low during FILL.
        read_addr = 32'h600; is_reading = 1'b1; done = 1'b1;
        settle();
        check("zl_rdy", 32'(is_ready), 32'd1);
        check("zl_data", read_data, mem_word(32'h600));
        check("zl_req", 32'(request), 32'd1);
        tick();
        done = 1'b0; is_reading = 1'b0;
        probe_hit(32'h600);
        read_addr = 32'h800; is_reading = 1'b1;
        tick();
        rdy_in = 1'b0; done = 1'b1;
        settle();
        check("frz_rdy", 32'(is_ready), 32'd0);
        check("frz_req", 32'(request), 32'd0);
        check("frz_avail", 32'(icache_available), 32'd0);
        tick();
        rdy_in = 1'b1; done = 1'b0;
        settle();
        check("frz_hold", 32'(icache_available), 32'd0);
        tick();
        done = 1'b1;
        settle();
        check("frz_done", 32'(is_ready), 32'd1);
        check("frz_data", read_data, mem_word(32'h800));
        tick();
        done = 1'b0; is_reading = 1'b0;
        probe_hit(32'h800);

        // Reset mid-FILL, then a stray done.
        read_addr = 32'h900; is_reading = 1'b1;
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0; is_reading = 1'b0; done = 1'b1;
        settle();
        check("rf_rdy", 32'(is_ready), 32'd0);
        check("rf_avail", 32'(icache_available), 32'd1);
        check("rf_req", 32'(request), 32'd0);
        tick();
        done = 1'b0;
        probe_miss(32'h800);

`ifdef ICACHE_PERF_EN
        do_reset();
        settle();
        check("perf_hit0", hit_count, 32'd0);
        check("perf_miss0", miss_count, 32'd0);
        tick();
        do_miss(32'h100, 1);
        probe_hit(32'h100);
        probe_hit(32'h100);
        probe_hit(32'h100);
        probe_miss(32'h300);
        settle();
        check("perf_hit", hit_count, 32'd3);
        check("perf_miss", miss_count, 32'd2);
        tick();
        do_reset();
        settle();
        check("perf_hit_rst", hit_count, 32'd0);
        check("perf_miss_rst", miss_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
